exp2_calc: RTL and testbench

EXP2_CALC -- requirements
Module: exp2_calc

---
 rtl/exp2_calc.sv | 183 ++++++++++++++++++
 tb/tb_exp2_calc.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/exp2_calc.sv
// exp2_calc: computes 2^x for x = integer_part + fraction_part and returns it
// as an IEEE754 single. The fractional power is a third-order series of
// e^(f*ln2) evaluated with one shared 24x24 shift-add multiplier; the integer
// part goes straight into the exponent field.
//
// Handshake: start is sampled only while idle (busy=0). Once accepted the
// operands are captured and all further inputs are ignored until done, which
// pulses for exactly one cycle together with the updated result. result holds
// its value between done pulses.
module exp2_calc #(
    parameter logic [23:0] LN2 = 24'hB17218
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  integer_part,
    input  logic [31:0] fraction_part,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        MUL_T  = 3'd2,
        MUL_SQ = 3'd3,
        MUL_CU = 3'd4,
        SUM    = 3'd5,
        PACK   = 3'd6,
        DONE   = 3'd7
    } state_t;

    state_t      state;
    logic [7:0]  int_q;
    logic [23:0] f_q;
    logic [23:0] t;
    logic [23:0] t2;
    logic [23:0] t3;
    logic [25:0] m_q;

    // Shared multiplier: operand registers, 48-bit accumulator, phase counter
    // (0 = operand load, 1..24 = iterations).
    logic [23:0] mul_a;
    logic [23:0] mul_b;
    logic [47:0] acc;
    logic [4:0]  mul_cnt;

    logic [23:0]       op_a;
    logic [23:0]       op_b;
    logic [24:0]       mul_sum;
    logic [47:0]       acc_next;
    logic [23:0]       t3_div6;
    logic [25:0]       m_sum;
    logic signed [9:0] e_val;
    logic [31:0]       pack_val;
    logic              unused_bits;

    assign state_dbg = state;

    // Low fraction bits are truncated away and m's top/bottom bits never
    // reach the fraction field.
    assign unused_bits = ^{fraction_part[7:0], m_q[25:24], m_q[0]};

    // Operand selection per product and one shift-add step: add the
    // multiplicand into the upper half when the current multiplier bit is
    // set, then shift right so that after 24 steps acc holds the full a*b.
    always_comb begin
        op_a = f_q;
        op_b = LN2;
        case (state)
            MUL_SQ: begin
                op_a = t;
                op_b = t;
            end
            MUL_CU: begin
                op_a = t2;
                op_b = t;
            end
            default: begin
                op_a = f_q;
                op_b = LN2;
            end
        endcase
        mul_sum  = {1'b0, acc[47:24]} + (mul_b[0] ? {1'b0, mul_a} : 25'd0);
        acc_next = {mul_sum, acc[23:1]};
    end

    // Series sum and IEEE754 packing; m is always in [2^24, 2^25) so the
    // fraction field is m[23:1] with no renormalisation.
    always_comb begin
        t3_div6 = t3 / 24'd6;
        m_sum   = 26'h100_0000 + {2'b00, t} + {3'b000, t2[23:1]} + {2'b00, t3_div6};
        e_val   = $signed({{2{int_q[7]}}, int_q}) + 10'sd127;
        if (e_val <= 10'sd0) begin
            pack_val = 32'h0000_0000;
        end else if (e_val >= 10'sd255) begin
            pack_val = 32'h7F80_0000;
        end else begin
            pack_val = {1'b0, e_val[7:0], m_q[23:1]};
        end
    end

    // Control FSM with registered outputs and the multiplier datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            result  <= 32'h0000_0000;
            done    <= 1'b0;
            busy    <= 1'b0;
            int_q   <= 8'd0;
            f_q     <= 24'd0;
            t       <= 24'd0;
            t2      <= 24'd0;
            t3      <= 24'd0;
            m_q     <= 26'd0;
            mul_a   <= 24'd0;
            mul_b   <= 24'd0;
            acc     <= 48'd0;
            mul_cnt <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        int_q <= integer_part;
                        f_q   <= fraction_part[31:8];
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    mul_cnt <= 5'd0;
                    state   <= MUL_T;
                end
                MUL_T, MUL_SQ, MUL_CU: begin
                    if (mul_cnt == 5'd0) begin
                        mul_a   <= op_a;
                        mul_b   <= op_b;
                        acc     <= 48'd0;
                        mul_cnt <= 5'd1;
                    end else begin
                        acc   <= acc_next;
                        mul_b <= mul_b >> 1;
                        if (mul_cnt == 5'd24) begin
                            mul_cnt <= 5'd0;
                            if (state == MUL_T) begin
                                t     <= acc_next[47:24];
                                state <= MUL_SQ;
                            end else if (state == MUL_SQ) begin
                                t2    <= acc_next[47:24];
                                state <= MUL_CU;
                            end else begin
                                t3    <= acc_next[47:24];
                                state <= SUM;
                            end
                        end else begin
                            mul_cnt <= mul_cnt + 5'd1;
                        end
                    end
                end
                SUM: begin
                    m_q   <= m_sum;
                    state <= PACK;
                end
                PACK: begin
                    result <= pack_val;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp2_calc.sv
// Directed bench for exp2_calc: hand-computed vectors for the exact cases,
// a small arithmetic reference for the pseudo-random vectors, latency/busy
// timing, ignored re-start, and reset abort.
module tb_exp2_calc;

    localparam longint LN2_REF = 64'h0000_0000_00B1_7218;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  integer_part;
    logic [31:0] fraction_part;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic [2:0]  state_dbg;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    // clock
    always #5 clk = ~clk;

    exp2_calc dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .integer_part (integer_part),
        .fraction_part(fraction_part),
        .result       (result),
        .done         (done),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    // Truncating series reference: 2^x = 2^i * (1 + t + t^2/2 + t^3/6), t = f*ln2.
    function automatic logic [31:0] model(input logic [7:0] ip, input logic [31:0] fp);
        longint f, t, t2, t3, m;
        int e;
        logic [7:0]  e8;
        logic [22:0] frac;
        f    = longint'(fp >> 8);
        t    = (f * LN2_REF) >> 24;
        t2   = (t * t) >> 24;
        t3   = (t2 * t) >> 24;
        m    = (longint'(1) << 24) + t + (t2 >> 1) + (t3 / 6);
        e    = int'($signed(ip)) + 127;
        e8   = e[7:0];
        frac = m[23:1];
        if (e <= 0) return 32'h0000_0000;
        else if (e >= 255) return 32'h7F80_0000;
        else return {1'b0, e8, frac};
    endfunction

    // Driver: called at a negedge with the DUT idle. Optionally re-pulses
    // start (with other operands) 'repulse' edges into the conversion.
    task automatic run_conv(input string tag, input logic [7:0] ip, input logic [31:0] fp,
                            input logic [31:0] want, input int repulse);
        int k;
        int busy_cnt;
        int extra_done;
        logic [31:0] e;
        integer_part  = ip;
        fraction_part = fp;
        start         = 1'b1;
        exp_q.push_back(want);
        @(negedge clk);
        start         = 1'b0;
        integer_part  = 8'($urandom);
        fraction_part = $urandom;
        k = 0;
        busy_cnt = 0;
        while (!done && k < 150) begin
            if (busy) busy_cnt++;
            start = (repulse != 0 && k == repulse);
            if (start) begin
                integer_part  = ip + 8'd7;
                fraction_part = fp ^ 32'hA5A5_0000;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check({tag, ":latency"}, 32'(k), 32'd78);
        check({tag, ":busy_cycles"}, 32'(busy_cnt), 32'd78);
        check({tag, ":busy_at_done"}, {31'd0, busy}, 32'd0);
        e = exp_q.pop_front();
        check({tag, ":result"}, result, e);
        @(negedge clk);
        check({tag, ":done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, ":result_hold"}, result, e);
        if (repulse != 0) begin
            extra_done = 0;
            repeat (90) begin
                if (done) extra_done++;
                @(negedge clk);
            end
            check({tag, ":single_done"}, 32'(extra_done), 32'd0);
            check({tag, ":result_after"}, result, e);
        end
    endtask

    initial begin
        int ndone;
        logic [7:0]  rip;
        logic [31:0] rfp;

        // reset
        rst = 1'b1;
        start = 1'b0;
        integer_part = 8'd0;
        fraction_part = 32'd0;
        repeat (3) @(negedge clk);
        check("rst:result", result, 32'h0);
        check("rst:done", {31'd0, done}, 32'd0);
        check("rst:busy", {31'd0, busy}, 32'd0);
        check("rst:state", {29'd0, state_dbg}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // directed vectors, back-to-back
        run_conv("zero",      8'd0,    32'h0000_0000, 32'h3F80_0000, 0);
        run_conv("int3",      8'd3,    32'h0000_0000, 32'h4100_0000, 0);
        run_conv("int_m126",  8'h82,   32'h0000_0000, 32'h0080_0000, 0);
        run_conv("int_m127",  8'h81,   32'h1234_5678, 32'h0000_0000, 0);
        run_conv("int_m128",  8'h80,   32'hFFFF_FFFF, 32'h0000_0000, 0);
        run_conv("int127",    8'd127,  32'h0000_0000, 32'h7F00_0000, 0);
        run_conv("sqrt2",     8'd0,    32'h8000_0000, 32'h3FB4_EFCD, 0);
        run_conv("trunc_lsb", 8'd0,    32'h0000_00FF, 32'h3F80_0000, 0);
        run_conv("int_m1",    8'hFF,   32'h0000_0000, 32'h3F00_0000, 0);
        run_conv("repulse",   8'd5,    32'h0000_0000, 32'h4200_0000, 10);

        // reset 40 edges into a conversion aborts it
        integer_part = 8'd2;
        fraction_part = 32'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort:done", {31'd0, done}, 32'd0);
        check("abort:busy", {31'd0, busy}, 32'd0);
        check("abort:result", result, 32'h0);
        check("abort:state", {29'd0, state_dbg}, 32'd0);
        ndone = 0;
        repeat (100) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("abort:no_done", 32'(ndone), 32'd0);

        // start together with reset is ignored
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("rst_start:busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("rst_start:busy_after", {31'd0, busy}, 32'd0);
        check("rst_start:state", {29'd0, state_dbg}, 32'd0);

        // first start after reset
        run_conv("post_rst", 8'd2, 32'h0000_0000, 32'h4080_0000, 0);

        // pseudo-random operands against the reference
        for (int i = 0; i < 30; i++) begin
            rip = 8'($urandom_range(0, 255));
            rfp = $urandom;
            run_conv("rand", rip, rfp, model(rip, rfp), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
